uart_tx_ctrl: RTL and testbench

- Frame sequencer for the UART transmit path.
- Accepts a byte handshake and drives the serializer's enable.
- Generates start, parity and stop bits; selects the line value on TX_OUT.
- Sits between the TX host interface and the serializer. Runs on the bit-rate clock: one clk cycle = one bit time.

---
 rtl/uart_tx_ctrl.sv | 140 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer driving start, data, parity and stop bits.
// Define UART_TX_TWO_STOP_EN to append a second stop bit to every frame.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int WDOG_SLACK = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int WDOG_LIMIT = DATA_WIDTH + WDOG_SLACK;
    localparam int WDOG_W     = $clog2(WDOG_LIMIT + 1);

`ifdef UART_TX_TWO_STOP_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t            state;
    state_t            next_state;
    logic              par_bit;
    logic              par_en_q;
    logic [WDOG_W-1:0] bit_cnt;
    logic              tx_q;
    logic              load_frame;
    logic              wdog_expired;
    logic              tx_d;
    logic              busy_d;
    logic              ser_en_d;

    // Next-state logic; load_frame marks the edge where a new byte is accepted.
    always_comb begin
        next_state   = state;
        load_frame   = 1'b0;
        wdog_expired = 1'b0;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    next_state = START;
                    load_frame = 1'b1;
                end
            end
            START: next_state = DATA;
            DATA: begin
                if (ser_done) begin
                    next_state = par_en_q ? PARITY : STOP;
                end else if (bit_cnt == WDOG_W'(WDOG_LIMIT - 1)) begin
                    next_state   = STOP;
                    wdog_expired = 1'b1;
                end
            end
            PARITY: next_state = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP: next_state = STOP2;
            STOP2: begin
                if (Data_Valid) begin
                    next_state = START;
                    load_frame = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
`else
            STOP: begin
                if (Data_Valid) begin
                    next_state = START;
                    load_frame = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from next_state so the registered values line up with the state.
    always_comb begin
        tx_d     = 1'b1;
        busy_d   = 1'b1;
        ser_en_d = 1'b0;
        case (next_state)
            IDLE:    busy_d   = 1'b0;
            START:   tx_d     = 1'b0;
            DATA:    ser_en_d = 1'b1;
            PARITY:  tx_d     = par_bit;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_q      <= 1'b1;
            ser_en    <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= next_state;
            tx_q      <= tx_d;
            ser_en    <= ser_en_d;
            busy      <= busy_d;
            frame_err <= wdog_expired;
        end
    end

    // bit_cnt counts DATA bit times and doubles as the ser_done watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            if (load_frame) begin
                par_bit  <= (^P_Data) ^ PAR_TYP;
                par_en_q <= PAR_EN;
            end
            if (state == START) begin
                bit_cnt <= '0;
            end else if (state == DATA) begin
                bit_cnt <= bit_cnt + WDOG_W'(1);
            end
        end
    end

    // During DATA the line follows the serializer bit directly.
    assign TX_OUT = ser_en ? ser_data : tx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: table-driven, directed and randomized checks of uart_tx_ctrl
// against a frame-level reference model and a serializer model.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int DW    = 8;
    localparam int SLACK = 2;
`ifdef UART_TX_TWO_STOP_EN
    localparam int XSTOP = 1;
`else
    localparam int XSTOP = 0;
`endif
    localparam int L = 10 + XSTOP;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          Data_Valid = 1'b0;
    logic [DW-1:0] P_Data     = '0;
    logic          PAR_EN     = 1'b0;
    logic          PAR_TYP    = 1'b0;
    logic          ser_done;
    logic          ser_data;
    logic          ser_en;
    logic          TX_OUT;
    logic          busy;
    logic          frame_err;

    logic          stall_req = 1'b0;
    logic          junk_done = 1'b0;
    logic [DW-1:0] sreg      = '0;
    int            scnt      = 0;
    logic          st_q      = 1'b0;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [3:0]    cur         = 4'b1000;
    bit            chk_en      = 1'b0;
    logic [3:0]    q[$];

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        pt;
        logic        st;
        int          len;
        logic [31:0] tx;
        int          sen;
        int          fpos;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .WDOG_SLACK(SLACK)) dut (
        .clk        (clk),
        .reset      (reset),
        .Data_Valid (Data_Valid),
        .P_Data     (P_Data),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    // Serializer: loads while idle, shifts LSB-first while enabled, never finishes when stalled.
    always @(posedge clk) begin
        if (!ser_en) begin
            sreg <= P_Data;
            scnt <= 0;
            st_q <= stall_req;
        end else begin
            sreg <= sreg >> 1;
            scnt <= scnt + 1;
        end
    end
    assign ser_data = sreg[0];
    assign ser_done = ser_en ? (!st_q && scnt == DW - 1) : junk_done;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: wait expired without DUT response at %0t", name, $time);
    endtask

    task automatic applyStimulus(input logic dv, input logic [DW-1:0] d, input logic pe,
                                 input logic pt, input logic st);
        Data_Valid = dv;
        P_Data     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        stall_req  = st;
    endtask

    // Expected per-cycle {TX_OUT, busy, ser_en, frame_err} for one whole frame.
    task automatic pushFrame(input logic [DW-1:0] d, input logic pe, input logic pt, input logic st);
        int ndata;
        ndata = st ? DW + SLACK : DW;
        q.push_back(4'b0100);
        for (int i = 0; i < ndata; i++)
            q.push_back({(i < DW) ? d[i] : 1'b0, 3'b110});
        if (pe && !st)
            q.push_back({(^d) ^ pt, 3'b100});
        q.push_back({3'b110, st});
        if (XSTOP != 0)
            q.push_back(4'b1100);
    endtask

    task automatic modelStep();
        if (reset) begin
            q.delete();
            cur = 4'b1000;
        end else begin
            if (q.size() == 0 && Data_Valid)
                pushFrame(P_Data, PAR_EN, PAR_TYP, stall_req);
            cur = (q.size() > 0) ? q.pop_front() : 4'b1000;
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en)
            checkOutput("line", 32'({TX_OUT, busy, ser_en, frame_err}), 32'(cur));
    end

    initial forever begin
        @(negedge clk);
        junk_done = 1'($urandom_range(0, 1));
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] aborting");
    end

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) timeoutFail(name);
    endtask

    task automatic waitSerEnRise(input string name);
        int n;
        n = 0;
        while (ser_en !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (ser_en !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) timeoutFail(name);
    endtask

    initial begin
        int          len;
        int          sen;
        int          fpos;
        logic [31:0] txv;
        logic [31:0] bv;
        logic [31:0] exp_tx;

        // tx bit k = TX_OUT in frame cycle k, single-stop framing
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 32'h34A,  8, -1};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 11, 32'h60E,  8, -1};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 11, 32'h40E,  8, -1};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 11, 32'h400,  8, -1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 11, 32'h7FE,  8, -1};
        vecs[5] = '{8'hA5, 1'b1, 1'b0, 1'b1, 12, 32'h94A, 10, 11};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("reset_idle", 32'({TX_OUT, busy, ser_en, frame_err}), 32'h8);
        end

        for (int v = 0; v < 6; v++) begin
            waitIdle("tbl_idle");
            applyStimulus(1'b1, vecs[v].d, vecs[v].pe, vecs[v].pt, vecs[v].st);
            @(negedge clk);
            Data_Valid = 1'b0;
            len  = 0;
            sen  = 0;
            fpos = -1;
            txv  = '0;
            while (busy === 1'b1 && len < 24) begin
                txv[len] = TX_OUT;
                if (ser_en === 1'b1) sen++;
                if (frame_err === 1'b1) fpos = len;
                len++;
                // Mid-frame changes must not leak into the current frame.
                if (len == 2) begin
                    PAR_EN  = ~PAR_EN;
                    PAR_TYP = ~PAR_TYP;
                    P_Data  = ~P_Data;
                end
                @(negedge clk);
            end
            exp_tx = vecs[v].tx | ((XSTOP != 0) ? (32'd1 << vecs[v].len) : 32'd0);
            checkOutput($sformatf("tbl%0d_len", v), 32'(len), 32'(vecs[v].len + XSTOP));
            checkOutput($sformatf("tbl%0d_tx", v), txv, exp_tx);
            checkOutput($sformatf("tbl%0d_ser_en_cycles", v), 32'(sen), 32'(vecs[v].sen));
            checkOutput($sformatf("tbl%0d_frame_err_pos", v), 32'(fpos), 32'(vecs[v].fpos));
        end

        waitIdle("b2b_idle");
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        txv = '0;
        bv  = '0;
        for (int k = 0; k < 2 * L + 1; k++) begin
            @(negedge clk);
            txv[k] = TX_OUT;
            bv[k]  = busy;
            if (k == 1) P_Data = 8'h0F;
            if (k == L + 1) Data_Valid = 1'b0;
        end
        exp_tx = (32'h2AA | (32'(XSTOP) << 10))
               | ((32'h21E | (32'(XSTOP) << 10)) << L)
               | (32'd1 << (2 * L));
        checkOutput("b2b_line", txv, exp_tx);
        checkOutput("b2b_busy", bv, (32'd1 << (2 * L)) - 32'd1);
        checkOutput("b2b_no_gap", 32'(txv[L]), 32'd0);

        waitIdle("rst_idle");
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_ser_en", 32'(ser_en), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_frame", 32'({TX_OUT, busy, ser_en, frame_err}), 32'h8);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("after_reset_idle", 32'({TX_OUT, busy, ser_en, frame_err}), 32'h8);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 7) == 0));
            waitSerEnRise("rand_accept");
            if ($urandom_range(0, 2) != 0) begin
                Data_Valid = 1'b0;
                waitIdle("rand_idle");
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        Data_Valid = 1'b0;
        waitIdle("final_idle");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
